// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation engine: FSM states and latency.
package rsa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        EXP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Cycle (counted from the go-accepting edge) in which done is high on a legal modulus.
    function automatic int unsigned latency(input int unsigned width);
        return (width + 1) * (width + 1) + 1;
    endfunction

endpackage

// File: rtl/rsa_modexp_engine_if.sv
// Request/result bundle between the frame buffer side and the modexp engine.
interface rsa_modexp_engine_if #(
    parameter int WIDTH = 8
) ();

    logic             go;
    logic [WIDTH-1:0] input_text;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] mod;
    logic [WIDTH-1:0] output_text;
    logic             done;
    logic             busy;
    logic             error;

    modport master (
        output go, input_text, key, mod,
        input  output_text, done, busy, error
    );

    modport slave (
        input  go, input_text, key, mod,
        output output_text, done, busy, error
    );

endinterface

// File: rtl/rsa_mod_mult.sv
// Interleaved MSB-first modular multiplier: p = a*b mod m, one bit of a per cycle.
// The first step happens on the start edge, so done is high in the WIDTH+1-th cycle counting the start cycle.
module rsa_mod_mult #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH+1:0] acc_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // With acc, b < m the sum stays below 3m, so two conditional subtractions restore acc < m.
    function automatic logic [WIDTH+1:0] mac_step(
        input logic [WIDTH+1:0] acc,
        input logic             bit_i,
        input logic [WIDTH-1:0] bv,
        input logic [WIDTH-1:0] mv
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] m_ext;
        m_ext = {2'b00, mv};
        t = (acc << 1) + (bit_i ? {2'b00, bv} : '0);
        if (t >= m_ext) t = t - m_ext;
        if (t >= m_ext) t = t - m_ext;
        return t;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc_q <= mac_step('0, a[WIDTH-1], b, m);
                a_q   <= a << 1;
                b_q   <= b;
                m_q   <= m;
                cnt_q <= CNT_W'(WIDTH - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                acc_q <= mac_step(acc_q, a_q[WIDTH-1], b_q, m_q);
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign p = acc_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time right-to-left square-and-multiply engine: output_text = input_text^key mod mod.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                reset,
    rsa_modexp_engine_if.slave bus
);

    localparam int unsigned LAT   = latency(WIDTH);
    localparam int          CYC_W = $clog2(LAT);

    state_t           state_q;
    logic [WIDTH-1:0] text_q;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic             done_q;
    logic             busy_q;
    logic             err_q;
    logic             err_pend_q;
    logic             start_q;
    logic [CYC_W-1:0] cyc_q;

    logic [WIDTH-1:0] mul_a_a;
    logic [WIDTH-1:0] mul_a_b;
    logic [WIDTH-1:0] p_a;
    logic [WIDTH-1:0] p_b;
    logic             done_a;
    logic             done_b;
    logic             start_b;

    // Multiplier A does the input reduction (text*1) first, then the r*b products.
    always_comb begin
        mul_a_a = r_q;
        mul_a_b = b_q;
        if (state_q == REDUCE) begin
            mul_a_a = text_q;
            mul_a_b = WIDTH'(1);
        end
    end

    assign start_b = start_q && (state_q == EXP);

    rsa_mod_mult #(.WIDTH(WIDTH)) u_mul_a (
        .clk   (clk),
        .reset (reset),
        .start (start_q),
        .a     (mul_a_a),
        .b     (mul_a_b),
        .m     (mod_q),
        .p     (p_a),
        .done  (done_a)
    );

    rsa_mod_mult #(.WIDTH(WIDTH)) u_mul_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .a     (b_q),
        .b     (b_q),
        .m     (mod_q),
        .p     (p_b),
        .done  (done_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            text_q     <= '0;
            key_q      <= '0;
            mod_q      <= '0;
            r_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            start_q    <= 1'b0;
            cyc_q      <= '0;
        end else begin
            done_q  <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.go) begin
                        text_q <= bus.input_text;
                        key_q  <= bus.key;
                        mod_q  <= bus.mod;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        cyc_q  <= '0;
                        if (bus.mod < WIDTH'(2)) begin
                            err_pend_q <= 1'b1;
                            state_q    <= FINISH;
                        end else begin
                            err_pend_q <= 1'b0;
                            start_q    <= 1'b1;
                            state_q    <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    cyc_q <= cyc_q + CYC_W'(1);
                    if (done_a) begin
                        b_q     <= p_a;
                        r_q     <= WIDTH'(1);
                        start_q <= 1'b1;
                        state_q <= EXP;
                    end
                end
                EXP: begin
                    cyc_q <= cyc_q + CYC_W'(1);
                    // Both products are always computed; the key bit only selects whether r takes its result.
                    if (done_a && done_b) begin
                        if (key_q[0]) r_q <= p_a;
                        b_q   <= p_b;
                        key_q <= key_q >> 1;
                        if (cyc_q == CYC_W'(LAT - 2)) state_q <= FINISH;
                        else start_q <= 1'b1;
                    end
                end
                FINISH: begin
                    out_q   <= err_pend_q ? '0 : r_q;
                    err_q   <= err_pend_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.output_text = out_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.error       = err_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Bench for rsa_modexp_engine: 8-bit and 16-bit instances against a plain-arithmetic modexp model.
module tb_rsa_modexp_engine;
    import rsa_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rsa_modexp_engine_if #(.WIDTH(8))  bus8 ();
    rsa_modexp_engine_if #(.WIDTH(16)) bus16 ();

    rsa_modexp_engine #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    rsa_modexp_engine #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] prev8  = '0;
    logic [31:0] prev16 = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint unsigned model_modexp(input longint unsigned t, input longint unsigned k,
                                                     input longint unsigned m, input int w);
        longint unsigned r;
        longint unsigned b;
        if (m < 2) return 0;
        r = 1;
        b = t % m;
        for (int i = 0; i < w; i++) begin
            if (((k >> i) & 64'd1) == 64'd1) r = (r * b) % m;
            b = (b * b) % m;
        end
        return r;
    endfunction

    task automatic drive(input int w, input logic g, input logic [31:0] t, input logic [31:0] k,
                         input logic [31:0] m);
        if (w == 8) begin
            bus8.go = g;
            bus8.input_text = t[7:0];
            bus8.key = k[7:0];
            bus8.mod = m[7:0];
        end else begin
            bus16.go = g;
            bus16.input_text = t[15:0];
            bus16.key = k[15:0];
            bus16.mod = m[15:0];
        end
    endtask

    function automatic logic [31:0] s_out(input int w);
        return (w == 8) ? {24'd0, bus8.output_text} : {16'd0, bus16.output_text};
    endfunction
    function automatic logic s_done(input int w);
        return (w == 8) ? bus8.done : bus16.done;
    endfunction
    function automatic logic s_busy(input int w);
        return (w == 8) ? bus8.busy : bus16.busy;
    endfunction
    function automatic logic s_err(input int w);
        return (w == 8) ? bus8.error : bus16.error;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_out8"},  bus8.output_text, 0);
        chk({tag, "_done8"}, bus8.done, 0);
        chk({tag, "_busy8"}, bus8.busy, 0);
        chk({tag, "_err8"},  bus8.error, 0);
        chk({tag, "_out16"}, bus16.output_text, 0);
        chk({tag, "_busy16"}, bus16.busy, 0);
    endtask

    // One operation, checked every cycle from the go-accepting edge through the cycle after done.
    task automatic run_op(input int w, input logic [31:0] t_in, input logic [31:0] k_in,
                          input logic [31:0] m_in, input longint lit_res, input int lit_lat,
                          input bit repulse, input int rst_at);
        logic [31:0] mask;
        logic [31:0] t, k, m, prev;
        longint unsigned exp_r;
        bit   exp_e;
        int   lat;
        int   done_at;
        mask = (w == 8) ? 32'h0000_00FF : 32'h0000_FFFF;
        t = t_in & mask;
        k = k_in & mask;
        m = m_in & mask;
        exp_e = (m < 2);
        exp_r = model_modexp(t, k, m, w);
        lat = exp_e ? 1 : (w + 1) * (w + 1) + 1;
        prev = (w == 8) ? prev8 : prev16;
        done_at = -1;

        @(negedge clk);
        drive(w, 1'b1, t, k, m);
        @(negedge clk);
        for (int c = 0; c <= lat; c++) begin
            if (c == rst_at) begin
                reset = 1'b0;
                #1;
                chk_idle_zero("async_reset");
                prev8 = '0;
                prev16 = '0;
                drive(w, 1'b0, '0, '0, '0);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("reset_no_done", s_done(w), 0);
                    chk("reset_no_busy", s_busy(w), 0);
                end
                reset = 1'b1;
                return;
            end
            chk("busy", s_busy(w), 1);
            chk("done", s_done(w), (c == lat));
            if (s_done(w) && done_at < 0) done_at = c;
            if (c < lat) begin
                chk("hold_out", s_out(w), prev);
                chk("err_low", s_err(w), 0);
            end else begin
                chk("result", s_out(w), exp_r);
                chk("error", s_err(w), exp_e);
                if (lit_res >= 0) chk("lit_result", s_out(w), lit_res);
            end
            // Operands are scrambled every cycle; only the captured ones may matter.
            drive(w, repulse && (c == 10 || c == 50), $urandom, $urandom, $urandom);
            @(negedge clk);
        end
        chk("busy_after", s_busy(w), 0);
        chk("done_after", s_done(w), 0);
        chk("out_after", s_out(w), exp_r);
        if (lit_lat >= 0) chk("lit_latency", done_at, lit_lat);
        drive(w, 1'b0, '0, '0, '0);
        if (w == 8) prev8 = 32'(exp_r);
        else prev16 = 32'(exp_r);
    endtask

    initial begin
        drive(8, 1'b0, '0, '0, '0);
        drive(16, 1'b0, '0, '0, '0);
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);

        // Textbook vectors and round trips.
        run_op(8, 2, 7, 143, 128, 82, 1'b0, -1);
        run_op(8, 128, 103, 143, 2, 82, 1'b0, -1);
        run_op(8, 200, 1, 143, 57, 82, 1'b0, -1);
        run_op(8, 99, 0, 143, 1, 82, 1'b0, -1);

        // Illegal moduli, then a legal go clears error.
        run_op(8, 37, 5, 1, 0, 1, 1'b0, -1);
        run_op(8, 5, 3, 143, 125, 82, 1'b0, -1);
        run_op(8, 200, 9, 0, 0, 1, 1'b0, -1);

        // go re-pulsed mid-run with new operands.
        run_op(8, 77, 13, 221, -1, 82, 1'b1, -1);

        // Reset mid-run, then a fresh operation.
        run_op(8, 10, 9, 187, -1, -1, 1'b0, 40);
        @(negedge clk);
        run_op(8, 10, 9, 187, -1, 82, 1'b0, -1);

        // Boundaries: zero base, zero key, maximum modulus.
        run_op(8, 0, 5, 143, 0, -1, 1'b0, -1);
        run_op(8, 0, 0, 143, 1, -1, 1'b0, -1);
        run_op(8, 254, 255, 255, -1, -1, 1'b0, -1);
        run_op(8, 255, 3, 255, 0, -1, 1'b0, -1);
        run_op(8, 3, 255, 2, 1, -1, 1'b0, -1);

        // 16-bit instance.
        run_op(16, 65, 17, 3233, 2790, 290, 1'b0, -1);
        run_op(16, 2790, 2753, 3233, 65, -1, 1'b0, -1);

        for (int i = 0; i < 25; i++)
            run_op(8, $urandom, $urandom, $urandom_range(0, 255), -1, -1, 1'b0, -1);
        for (int i = 0; i < 2; i++)
            run_op(16, $urandom, $urandom, $urandom_range(2, 65535), -1, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
- Parametrised, constant-time modular-exponentiation engine: output_text = input_text^key mod mod.
- Next-generation RSA core for the RFID tag/reader datapath.
- Adds over the previous core:
  - a WIDTH parameter;
  - a busy flag;
  - an error flag for illegal moduli;
  - fixed latency independent of key value;
  - input operand capture.
- Sits between the RFID frame buffer and the tag response encoder.

Parameters:
- WIDTH, 8, operand width in bits for text, key, modulus and result (legal 4..32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- go  input  1  start request; sampled only while idle.
- input_text  input  WIDTH  message/ciphertext operand.
- key  input  WIDTH  exponent (e or d).
- mod  input  WIDTH  modulus n.
- output_text  output  WIDTH  result; held stable between done and the next accepted go.
- done  output  1  single-cycle completion pulse.
- busy  output  1  high from the cycle after go is accepted until the done cycle, inclusive.
- error  output  1  high with done when mod < 2; cleared on the next accepted go.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; output_text=0, done=0, busy=0, error=0.
  - All internal registers are cleared.
  - Mid-operation reset aborts the computation with no done pulse.
- go handling:
  - go is accepted on a rising edge in IDLE; input_text, key and mod are captured into internal registers on that edge.
  - Later input changes have no effect.
  - go while busy is ignored; it is neither queued nor an error.
- States: IDLE, REDUCE, EXP, FINISH.
  - IDLE: go=1 with mod<2 -> FINISH with error=1 and output_text=0. go=1 otherwise -> REDUCE.
  - REDUCE: b = input_text*1 mod m, using multiplier A. r = 1. Takes WIDTH+1 cycles, then -> EXP.
  - EXP: WIDTH iterations, key bits LSB first. Each iteration runs two multipliers in parallel for WIDTH+1 cycles:
    - A computes r*b mod m;
    - B computes b*b mod m;
    - r is updated with A's result only if the current key bit = 1; b is always updated with B's result;
    - both multiplies always execute (constant time);
    - after the last bit -> FINISH.
  - FINISH: output_text=r, done=1 for exactly one cycle, busy=1 in this cycle, then -> IDLE.
- Latency, measured from the go-accepting edge:
  - normal operation: done is high in cycle (WIDTH+1)^2+1, which is 82 for WIDTH=8;
  - error path (mod<2): done is high in cycle 1.
- Arithmetic:
  - All intermediates are < m.
  - Multiplier accumulator is WIDTH+2 bits.
  - Each step is acc = 2*acc + (a_bit ? b : 0), followed by up to two conditional subtractions of m.
  - Result is exact for any m in [2, 2^WIDTH-1].
- Boundary conditions:
  - key=0 -> output_text=1.
  - input_text >= mod -> reduced first.
  - input_text=0 -> 0, unless key=0.
  - mod = 2^WIDTH-1 must not overflow.
- go held high continuously: a new operation starts in the cycle after FINISH returns to IDLE.

Decomposition:
- Shared package rsa_pkg:
  - state enumeration (IDLE, REDUCE, EXP, FINISH);
  - a latency constant function, (WIDTH+1)^2+1, used by the RTL and the bench.
- One sub-module, rsa_mod_mult (instantiated twice):
  - interleaved MSB-first modular multiplier;
  - ports: start, a, b, m, p, done;
  - done is a pulse exactly WIDTH+1 cycles after start;
  - requires a, b < m.

Test Plan:
1. WIDTH=8, text=2, key=7, mod=143, go pulse -> done at cycle 82, output_text=128, error=0. Then text=128, key=103 -> output_text=2 (round trip).
2. WIDTH=8, text=200, key=1, mod=143 -> 57. text=99, key=0, mod=143 -> 1. Latency is 82 in both cases (constant time, independent of key).
3. WIDTH=8, mod=1, any text/key -> done at cycle 1, error=1, output_text=0. The next valid go clears error.
4. WIDTH=8, go re-pulsed at cycles 10 and 50 of a run, with input operands changed mid-run -> result is that of the original operands, one done pulse only, busy continuous.
5. Reset asserted at cycle 40 of a run -> outputs 0 immediately (asynchronously), no done. A fresh go after release gives the correct result at cycle 82.
6. WIDTH=16, text=65, key=17, mod=3233 -> 2790 at cycle 290. Then key=2753 on 2790 -> 65.
